// File: rtl/my_nios_pio_in.sv
// my_nios_pio_in: Avalon-MM slave input PIO.
// The external in_port bus passes through a synchronizer and can be read as
// DATA. Selected edges are latched into a sticky EDGECAP register, and irq is
// raised for any captured edge whose IRQMASK bit is set.
// Word addresses: 0 DATA (ro), 1 reserved, 2 IRQMASK (rw), 3 EDGECAP (write 1 to clear).
module my_nios_pio_in #(
    parameter int WIDTH       = 8,  // 1..32
    parameter int EDGE_TYPE   = 0,  // 0 rising, 1 falling, 2 any
    parameter int SYNC_STAGES = 2   // 2..4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Once the counter reaches SYNC_STAGES+1, the synchronizer and prev hold real
    // post-reset samples. Before that point, edges are artefacts of the reset value.
    localparam int         PRIME_W    = 3;
    localparam logic [2:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]   sync [SYNC_STAGES];
    logic [WIDTH-1:0]   sync_q;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   irqmask;
    logic [WIDTH-1:0]   edgecap;
    logic [WIDTH-1:0]   edge_det;
    logic [WIDTH-1:0]   clr;
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed;
    logic               wr_valid;
    logic               unused_writedata;

    assign sync_q   = sync[SYNC_STAGES-1];
    assign primed   = (prime_cnt == PRIME_DONE);
    assign wr_valid = chipselect & ~write_n;
    assign clr      = (wr_valid && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Upper writedata bits have no destination when WIDTH < 32.
    assign unused_writedata = ^writedata;

    // Synchronizer chain, plus a one-clock-delayed copy of its output for edge detection.
    // NOTE: this chain is only a few flops, so every stage is reset. A clean post-reset
    // history is what allows the priming counter to bound spurious edges. Larger
    // storage arrays would normally be left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync[i] <= '0;
            end
            prev <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage take its neighbour's
            // old value. Blocking assignments would collapse the chain into a
            // single flop.
            sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev <= sync_q;
        end
    end

    // Priming counter: counts clocks after reset release, then holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    // Per-bit edge detection for the configured edge type.
    always_comb begin
        // NOTE: assigning a default first means every path drives edge_det,
        // so no latch is inferred.
        edge_det = sync_q ^ prev;
        case (EDGE_TYPE)
            0:       edge_det = sync_q & ~prev;
            1:       edge_det = ~sync_q & prev;
            default: edge_det = sync_q ^ prev;
        endcase
    end

    // IRQMASK register and sticky EDGECAP. A new edge wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            if (wr_valid && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecap <= (primed ? edge_det : '0) | (edgecap & ~clr);
        end
    end

    // Zero-latency read mux, independent of chipselect and zero-extended to 32 bits.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_my_nios_pio_in.sv
// Testbench for my_nios_pio_in. Two instances share one bus and one in_port:
// dut0 uses rising-edge capture and dut2 uses any-edge capture. A history-based
// model predicts both instances every cycle, and directed literal checks pin
// the model to hand-computed values.
module tb_my_nios_pio_in;

    localparam int N  = 2;
    localparam int HL = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [7:0]  in_port = 8'h00;
    logic [31:0] rd0, rd2;
    logic        irq0, irq2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    my_nios_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(N)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0)
    );

    my_nios_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(N)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_port), .irq(irq2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: samp[c] is the in_port value sampled at post-reset clock edge c.
    // DATA after edge c shows samp[c-N+1]. At edge c, the capture compares
    // samp[c-N] against samp[c-N-1], and only does so from edge N+2 onward.
    logic [7:0] samp [HL];
    int         cyc;
    logic [7:0] m_mask, m_cap0, m_cap2;

    function automatic logic [7:0] smp(input int j);
        return (j >= 1) ? samp[j % HL] : 8'h00;
    endfunction

    function automatic logic [7:0] m_rise(input int c);
        return (c >= N + 2) ? (smp(c - N) & ~smp(c - N - 1)) : 8'h00;
    endfunction

    function automatic logic [7:0] m_any(input int c);
        return (c >= N + 2) ? (smp(c - N) ^ smp(c - N - 1)) : 8'h00;
    endfunction

    function automatic logic [7:0] m_clr();
        return (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
    endfunction

    function automatic logic [31:0] m_rd(input logic [7:0] cap);
        case (address)
            2'd0:    return {24'h0, smp(cyc - N + 1)};
            2'd1:    return 32'h0;
            2'd2:    return {24'h0, m_mask};
            default: return {24'h0, cap};
        endcase
    endfunction

    // Advance the model one clock edge, or clear it on reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc    <= 0;
            m_mask <= 8'h00;
            m_cap0 <= 8'h00;
            m_cap2 <= 8'h00;
        end else begin
            cyc <= cyc + 1;
            samp[(cyc + 1) % HL] <= in_port;
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[7:0];
            m_cap0 <= m_rise(cyc + 1) | (m_cap0 & ~m_clr());
            m_cap2 <= m_any(cyc + 1)  | (m_cap2 & ~m_clr());
        end
    end

    // Compare both instances against the model shortly after every active edge.
    always begin
        @(posedge clk);
        #2;
        if (reset_n) begin
            check("cmp_rd0",  rd0,  m_rd(m_cap0));
            check("cmp_irq0", {31'h0, irq0}, {31'h0, |(m_cap0 & m_mask)});
            check("cmp_rd2",  rd2,  m_rd(m_cap2));
            check("cmp_irq2", {31'h0, irq2}, {31'h0, |(m_cap2 & m_mask)});
        end
    end

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic read0(input logic [1:0] a, input string name, input logic [31:0] exp);
        address = a;
        #1;
        check(name, rd0, exp);
    endtask

    initial begin
        // Reset state, with in_port held high through reset.
        in_port = 8'hFF;
        repeat (3) @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check("reset_rd0", rd0, 32'h0);
            check("reset_rd2", rd2, 32'h0);
        end
        check("reset_irq0", {31'h0, irq0}, 32'h0);

        // Release reset with IRQMASK=FF. DATA becomes FF after 2 clocks; priming suppresses capture.
        reset_n = 1'b1;
        write_reg(2'd2, 32'hFF);
        @(negedge clk);
        read0(2'd0, "prime_data", 32'hFF);
        repeat (6) @(negedge clk);
        read0(2'd3, "prime_edgecap", 32'h0);
        check("prime_irq0", {31'h0, irq0}, 32'h0);
        check("prime_irq2", {31'h0, irq2}, 32'h0);

        // Falling edges on all bits: captured only by the any-edge instance.
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        read0(2'd3, "fall_rise_inst", 32'h0);
        check("fall_any_inst", rd2, 32'hFF);
        write_reg(2'd3, 32'hFF);
        write_reg(2'd2, 32'h01);

        // Rising edge on bit0 set up before edge k.
        in_port = 8'h01;
        @(negedge clk);
        read0(2'd0, "rise_data_k", 32'h00);
        @(negedge clk);
        read0(2'd0, "rise_data_k1", 32'h01);
        @(negedge clk);
        read0(2'd3, "rise_cap_k2", 32'h01);
        check("rise_irq_k2", {31'h0, irq0}, 32'h1);
        write_reg(2'd3, 32'h01);
        read0(2'd3, "rise_cleared", 32'h00);
        check("rise_irq_cleared", {31'h0, irq0}, 32'h0);

        // Masking: edges captured on bits 3 and 5.
        write_reg(2'd2, 32'h08);
        in_port = 8'h29;
        repeat (3) @(negedge clk);
        read0(2'd3, "mask_cap", 32'h28);
        check("mask_irq_b3", {31'h0, irq0}, 32'h1);
        write_reg(2'd2, 32'h20);
        check("mask_irq_b5", {31'h0, irq0}, 32'h1);
        write_reg(2'd3, 32'h20);
        check("mask_irq_off", {31'h0, irq0}, 32'h0);
        read0(2'd3, "mask_cap_left", 32'h08);

        // A clear on bit2 in the same cycle as a new bit2 edge leaves the bit set.
        in_port = 8'h2D;
        @(negedge clk);
        @(negedge clk);
        write_reg(2'd3, 32'h04);
        read0(2'd3, "collide_cap", 32'h0C);

        // Falling edge on bit7: captured only by the any-edge instance.
        in_port = 8'hAD;
        repeat (4) @(negedge clk);
        write_reg(2'd3, 32'hFF);
        in_port = 8'h2D;
        repeat (3) @(negedge clk);
        read0(2'd3, "any_rise_inst", 32'h00);
        check("any_any_inst", rd2, 32'h80);

        // Register map hygiene.
        write_reg(2'd0, 32'hFFFF_FFFF);
        write_reg(2'd1, 32'hFFFF_FFFF);
        read0(2'd1, "hyg_addr1", 32'h0);
        read0(2'd0, "hyg_data", 32'h2D);
        read0(2'd2, "hyg_mask_kept", 32'h20);
        write_reg(2'd2, 32'hFFFF_FFFF);
        read0(2'd2, "hyg_mask_ext", 32'h0000_00FF);

        // Reset during capture: irq and all registers drop asynchronously.
        in_port = 8'h6D;
        repeat (3) @(negedge clk);
        check("mid_irq_before", {31'h0, irq0}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_irq0", {31'h0, irq0}, 32'h0);
        check("mid_irq2", {31'h0, irq2}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check("mid_rd0", rd0, 32'h0);
            check("mid_rd2", rd2, 32'h0);
        end

        // Release again with in_port high: priming restarts.
        in_port = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        read0(2'd3, "reprime_cap", 32'h0);
        check("reprime_cap2", rd2, 32'h0);
        read0(2'd0, "reprime_data", 32'hFF);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/my_nios_pio_in.md
# my_nios_pio_in

Avalon-MM slave input PIO for the Nios II system: the read-side counterpart of the existing output PIO. It samples an external `in_port` bus through a synchronizer and exposes the value as a register. It latches configurable edges into a sticky edge-capture register and raises a level interrupt for any captured edge whose mask bit is set. It sits on the CPU data master bus beside the output PIO and uses the same 2-bit word address and 32-bit data conventions.

## Interface
- `WIDTH`, 8: width of `in_port` and of all per-bit registers (1..32).
- `EDGE_TYPE`, 0: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.
- `SYNC_STAGES`, 2: synchronizer depth (2..4).

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data; combinational, read latency 0.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `irq`  out  1  level interrupt, active-high.

## Operation
- **Register map:**
  - 0 DATA: read-only, returns synchronized `in_port`.
  - 1: reserved, reads 0, writes ignored.
  - 2 IRQMASK: read/write, bits [WIDTH-1:0].
  - 3 EDGECAP: read returns captured edges; write 1 clears that bit, write 0 has no effect.
- `readdata` is zero-extended above WIDTH. It is driven from `address` regardless of `chipselect`.
- **Synchronizer:** a chain `sync[0..SYNC_STAGES-1]` samples `in_port` every clock. `sync_q` is `sync[last]`, and `prev` holds `sync_q` delayed one clock.
- **Edge detect** (per bit):
  - rising = `sync_q & ~prev`
  - falling = `~sync_q & prev`
  - any = XOR of the two.
- **Edge capture:** per bit, `edgecap <= edge_det | (edgecap & ~clr)`, where `clr = writedata` on a valid write to address 3. A new edge and a clear in the same cycle leave the bit set.
- **Priming counter:** counts clocks after reset release. Edge capture updates are inhibited until SYNC_STAGES+1 clocks have elapsed, so inputs already high at reset do not produce spurious rising edges. After that the counter saturates and is idle.
- **IRQ:** `irq = |(edgecap & irqmask)`, combinational from registers.
- Writes to address 0 or 1 are ignored.
- A valid write is `chipselect & ~write_n`. Reads have no side effects.

## Timing
- **Reset values:** sync chain, prev, irqmask, edgecap and priming counter are all 0. `irq` = 0. `readdata` follows `address` (0 for all addresses at reset).
- **Reset mid-operation:** all state clears asynchronously, priming restarts, and `irq` drops immediately.
- **Latency**, for an input change set up before clock edge k (SYNC_STAGES=N):
  - DATA reflects it after edge k+N-1.
  - The EDGECAP bit sets at edge k+N.
  - `irq` asserts in the same cycle as the EDGECAP bit if masked in.
- **Register writes:** IRQMASK and EDGECAP writes take effect at the clock edge of the write cycle. `irq` updates the following cycle.
- **Pulse width:** input pulses shorter than one clock may be missed; no pulse stretching is provided.
- **Multiple edges:** an edge on a bit already set leaves it set. There is no overflow indication.

## Test plan
- **Reset:** hold `in_port`=8'hFF through reset release with IRQMASK=8'hFF.
  - DATA reads 8'hFF after 2 clocks.
  - EDGECAP stays 8'h00 and `irq` stays 0 (priming suppression).
- **Rising edge, EDGE_TYPE=0:**
  - Set IRQMASK=8'h01, drive bit0 0→1 before edge k.
  - DATA bit0 = 1 after edge k+1; EDGECAP = 8'h01 and `irq` = 1 after edge k+2.
  - Write 8'h01 to address 3: EDGECAP = 0, `irq` = 0 the next cycle.
- **Masking:**
  - Capture edges on bits 3 and 5 with IRQMASK=8'h08: `irq`=1.
  - Write IRQMASK=8'h20: `irq` stays 1.
  - Clear bit 5 via write 8'h20 to address 3: `irq`=0 and EDGECAP=8'h08.
- **Clear-vs-edge collision:** time a write-1 to EDGECAP bit2 in the same cycle a new rising edge is detected on bit2. EDGECAP bit2 remains 1.
- **EDGE_TYPE=2 (any edge):** toggle bit7 1→0. EDGECAP=8'h80. Falling edges with EDGE_TYPE=0 never set bits.
- **Register map hygiene:**
  - Write 32'hFFFFFFFF to addresses 0 and 1: no state change.
  - Address 1 reads 0.
  - IRQMASK reads 32'h000000FF after writing 32'hFFFFFFFF.
  - Assert `reset_n` low mid-capture: `irq` drops asynchronously and all registers read 0.
